// File: rtl/regfile_pkg.sv
// Shared defaults and types for the regfile_sb register file and its scoreboard.
package regfile_pkg;

    localparam int DATA_W_DFLT = 16;
    localparam int ADDR_W_DFLT = 3;
    localparam int NREGS_DFLT  = 1 << ADDR_W_DFLT;
    localparam int R0_RST_DFLT = 10;

    typedef logic [DATA_W_DFLT-1:0] reg_data_t;
    typedef logic [ADDR_W_DFLT-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared on writeback.
module regfile_scoreboard import regfile_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              mark_en,
    input  logic [ADDR_W-1:0] mark_addr,
    input  logic [ADDR_W-1:0] rd1_addr,
    input  logic [ADDR_W-1:0] rd2_addr,
    output logic              rd1_busy,
    output logic              rd2_busy,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int NREGS = 1 << ADDR_W;

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [ADDR_W:0]  cnt_s;

    // A mark in the writeback cycle wins: a new producer was issued for that register.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NREGS; i++) begin
            busy_d[i] = (mark_en && (mark_addr == ADDR_W'(i))) ? 1'b1 :
                        (wr_en && (wr_addr == ADDR_W'(i)))     ? 1'b0 : busy_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= {NREGS{1'b0}};
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        cnt_s = {(ADDR_W+1){1'b0}};
        for (int i = 0; i < NREGS; i++) begin
            cnt_s = cnt_s + (ADDR_W+1)'(busy_q[i]);
        end
    end

    // Writeback forwards, so a register being written this cycle is already not busy.
    always_comb begin
        rd1_busy = busy_q[rd1_addr] & ~(wr_en && (wr_addr == rd1_addr));
        rd2_busy = busy_q[rd2_addr] & ~(wr_en && (wr_addr == rd2_addr));
        busy_cnt = cnt_s;
    end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with write-first bypass and pending-write scoreboard.
// Define REGFILE_ZERO_REG_EN to hardwire register 0 to zero.
module regfile_sb import regfile_pkg::*; #(
    parameter int DATA_W = DATA_W_DFLT,
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int R0_RST = R0_RST_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd1_addr,
    input  logic [ADDR_W-1:0] rd2_addr,
    output logic [DATA_W-1:0] rd1_data,
    output logic [DATA_W-1:0] rd2_data,
    output logic              rd1_busy,
    output logic              rd2_busy,
    output logic              stall,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              mark_en,
    input  logic [ADDR_W-1:0] mark_addr,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int NREGS = 1 << ADDR_W;
`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif
    localparam logic [DATA_W-1:0] R0_INIT = ZERO_REG ? {DATA_W{1'b0}} : DATA_W'(R0_RST);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic              wr_en_s;
    logic              mark_en_s;

    // Suppressing index-0 traffic here keeps reg0 at zero and its busy bit clear everywhere.
    always_comb begin
        wr_en_s   = wr_en   & ~(ZERO_REG & (wr_addr   == {ADDR_W{1'b0}}));
        mark_en_s = mark_en & ~(ZERO_REG & (mark_addr == {ADDR_W{1'b0}}));
    end

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = (wr_en_s && (wr_addr == ADDR_W'(i))) ? wr_data : regs_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= (i == 0) ? R0_INIT : {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        if (wr_en_s && (wr_addr == rd1_addr)) begin
            rd1_data = wr_data;
        end else begin
            rd1_data = regs_q[rd1_addr];
        end
        if (wr_en_s && (wr_addr == rd2_addr)) begin
            rd2_data = wr_data;
        end else begin
            rd2_data = regs_q[rd2_addr];
        end
        stall = rd1_busy | rd2_busy;
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en_s),
        .wr_addr   (wr_addr),
        .mark_en   (mark_en_s),
        .mark_addr (mark_addr),
        .rd1_addr  (rd1_addr),
        .rd2_addr  (rd2_addr),
        .rd1_busy  (rd1_busy),
        .rd2_busy  (rd2_busy),
        .busy_cnt  (busy_cnt)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed plus randomized bench for regfile_sb against an array-based reference model.
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int NR = NREGS_DFLT;
`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO = 1'b1;
`else
    localparam bit ZERO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    reg_addr_t  rd1_addr = 3'd0, rd2_addr = 3'd0, wr_addr = 3'd0, mark_addr = 3'd0;
    reg_data_t  wr_data = 16'd0;
    logic       wr_en = 1'b0, mark_en = 1'b0;
    reg_data_t  rd1_data, rd2_data;
    logic       rd1_busy, rd2_busy, stall;
    logic [3:0] busy_cnt;

    int vectors = 0;
    int miscompares = 0;

    reg_data_t m_reg [NR];
    bit        m_busy [NR];

    regfile_sb dut (
        .clk(clk), .rst(rst),
        .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
        .rd1_data(rd1_data), .rd2_data(rd2_data),
        .rd1_busy(rd1_busy), .rd2_busy(rd2_busy), .stall(stall),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .mark_en(mark_en), .mark_addr(mark_addr), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic m_reset();
        for (int i = 0; i < NR; i++) begin
            m_reg[i]  = 16'd0;
            m_busy[i] = 1'b0;
        end
        m_reg[0] = ZERO ? 16'd0 : 16'd10;
    endtask

    function automatic bit hw_zero(input int a);
        return ZERO && (a == 0);
    endfunction

    function automatic reg_data_t exp_data(input int a);
        if (hw_zero(a)) return 16'd0;
        if (wr_en && (int'(wr_addr) == a)) return wr_data;
        return m_reg[a];
    endfunction

    function automatic bit exp_busy(input int a);
        if (wr_en && (int'(wr_addr) == a) && !hw_zero(a)) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic int exp_cnt();
        int n = 0;
        for (int i = 0; i < NR; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        bit b1, b2;
        #2;
        b1 = exp_busy(int'(rd1_addr));
        b2 = exp_busy(int'(rd2_addr));
        chk({tag, ".rd1_data"}, 32'(rd1_data), 32'(exp_data(int'(rd1_addr))));
        chk({tag, ".rd2_data"}, 32'(rd2_data), 32'(exp_data(int'(rd2_addr))));
        chk({tag, ".rd1_busy"}, 32'(rd1_busy), 32'(b1));
        chk({tag, ".rd2_busy"}, 32'(rd2_busy), 32'(b2));
        chk({tag, ".stall"},    32'(stall),    32'(b1 | b2));
        chk({tag, ".busy_cnt"}, 32'(busy_cnt), 32'(exp_cnt()));
    endtask

    // Model update from the architectural rules: write clears, a same-cycle mark re-sets.
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            if (wr_en && !hw_zero(int'(wr_addr))) begin
                m_reg[wr_addr]  = wr_data;
                m_busy[wr_addr] = 1'b0;
            end
            if (mark_en && !hw_zero(int'(mark_addr))) m_busy[mark_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; mark_en = 1'b0;
    endtask

    initial begin
        m_reset();
        rd1_addr = 3'd0; rd2_addr = 3'd5;
        tick(); tick();
        check_all("in_reset");
        rst = 1'b0;
        check_all("reset_release");
        chk("reset.r0", 32'(rd1_data), ZERO ? 32'd0 : 32'd10);

        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h1234; rd1_addr = 3'd3;
        check_all("bypass");
        chk("bypass.lit", 32'(rd1_data), 32'h1234);
        tick(); idle();
        check_all("bypass_hold");

        mark_en = 1'b1; mark_addr = 3'd2; rd2_addr = 3'd2;
        check_all("mark_same_cycle");
        tick(); idle();
        check_all("mark_next");
        chk("mark.cnt", 32'(busy_cnt), 32'd1);
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'd7;
        check_all("wb_forward");
        tick(); idle();
        check_all("wb_after");

        wr_en = 1'b1; mark_en = 1'b1; wr_addr = 3'd4; mark_addr = 3'd4; wr_data = 16'd9;
        rd1_addr = 3'd4; rd2_addr = 3'd4;
        tick(); idle();
        check_all("collision");

        for (int i = 0; i < NR; i++) begin
            mark_en = 1'b1; mark_addr = 3'(i);
            tick();
        end
        idle();
        rd1_addr = 3'd0; rd2_addr = 3'd7;
        check_all("fill");
        #1 rst = 1'b1;
        m_reset();
        check_all("async_rst");
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h5555; rd2_addr = 3'd1;
        tick();
        rst = 1'b0; idle();
        check_all("wr_lost_in_rst");

        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF;
        mark_en = 1'b1; mark_addr = 3'd0; rd1_addr = 3'd0; rd2_addr = 3'd0;
        check_all("r0_write");
        tick(); idle();
        check_all("r0_after");

        for (int n = 0; n < 300; n++) begin
            wr_en     = 1'($urandom_range(0, 1));
            mark_en   = 1'($urandom_range(0, 1));
            wr_addr   = 3'($urandom_range(0, NR - 1));
            mark_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom_range(0, NR - 1));
            rd1_addr  = 3'($urandom_range(0, NR - 1));
            rd2_addr  = ($urandom_range(0, 3) == 0) ? rd1_addr : 3'($urandom_range(0, NR - 1));
            wr_data   = 16'($urandom);
            check_all("random");
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
